// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher: forward key expansion to rk10, then inverse rounds with an
// on-the-fly inverse key schedule. Optional key cache enabled by AES_INV_KEY_CACHE_EN.
module aes_inv_cipher #(
  parameter bit CLEAR_OUTPUT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_in,
  output logic         ready_in,
  input  logic [127:0] ciphertext_in,
  input  logic [127:0] key_in,
  input  logic         ready_out,
  output logic         valid_out,
  output logic [127:0] plaintext_out
);

  typedef enum logic [2:0] {StIdle, StKeyexp, StInit, StRound, StFinal, StDone} st_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // InvShiftRows followed by InvSubBytes; byte b sits at row b%4, column b/4.
  function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
    logic [127:0] o;
    int           src;
    o = '0;
    for (int b = 0; b < 16; b++) begin
      src = (b % 4) + 4 * (((b / 4) + 4 - (b % 4)) % 4);
      o[127-8*b -: 8] = inv_sbox(s[127-8*src -: 8]);
    end
    return o;
  endfunction

  // k selects the xtime multiples: 9 = 4'b1001, 11 = 4'b1011, 13 = 4'b1101, 14 = 4'b1110.
  function automatic logic [7:0] gmul_k(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul_k(a0, 4'he) ^ gmul_k(a1, 4'hb) ^ gmul_k(a2, 4'hd) ^ gmul_k(a3, 4'h9);
      o[119-32*c -: 8] = gmul_k(a0, 4'h9) ^ gmul_k(a1, 4'he) ^ gmul_k(a2, 4'hb) ^ gmul_k(a3, 4'hd);
      o[111-32*c -: 8] = gmul_k(a0, 4'hd) ^ gmul_k(a1, 4'h9) ^ gmul_k(a2, 4'he) ^ gmul_k(a3, 4'hb);
      o[103-32*c -: 8] = gmul_k(a0, 4'hb) ^ gmul_k(a1, 4'hd) ^ gmul_k(a2, 4'h9) ^ gmul_k(a3, 4'he);
    end
    return o;
  endfunction

  st_e          st_q, st_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         valid_q, valid_d;
  logic [127:0] pt_q, pt_d;

  logic [31:0]  ks_word;
  logic [31:0]  ks_f;
  logic [127:0] key_fwd;
  logic [127:0] key_inv;
  logic [31:0]  inv_w3;
  logic [127:0] sr_sb;

  // One SubWord unit serves both schedules: forward uses w3, inverse uses the recovered w3.
  assign inv_w3  = key_q[31:0] ^ key_q[63:32];
  assign ks_word = (st_q == StKeyexp) ? key_q[31:0] : inv_w3;
  assign ks_f    = {sbox(ks_word[23:16]), sbox(ks_word[15:8]), sbox(ks_word[7:0]),
                    sbox(ks_word[31:24])} ^ {rcon(rnd_q), 24'h0};

  always_comb begin
    key_fwd[127:96] = key_q[127:96] ^ ks_f;
    key_fwd[95:64]  = key_q[95:64] ^ key_fwd[127:96];
    key_fwd[63:32]  = key_q[63:32] ^ key_fwd[95:64];
    key_fwd[31:0]   = key_q[31:0] ^ key_fwd[63:32];
  end

  assign key_inv = {key_q[127:96] ^ ks_f, key_q[127:96] ^ key_q[95:64],
                    key_q[95:64] ^ key_q[63:32], inv_w3};
  assign sr_sb   = inv_sr_sb(state_q);

`ifdef AES_INV_KEY_CACHE_EN
  logic [127:0] cache_key_q, cache_key_d;
  logic [127:0] cache_rk_q, cache_rk_d;
  logic         cache_vld_q, cache_vld_d;
`endif

  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    valid_d = valid_q;
    pt_d    = pt_q;
`ifdef AES_INV_KEY_CACHE_EN
    cache_key_d = cache_key_q;
    cache_rk_d  = cache_rk_q;
    cache_vld_d = cache_vld_q;
`endif
    case (st_q)
      StIdle: begin
        if (valid_in) begin
          state_d = ciphertext_in;
          key_d   = key_in;
          rnd_d   = 4'd1;
          st_d    = StKeyexp;
`ifdef AES_INV_KEY_CACHE_EN
          if (cache_vld_q && (key_in == cache_key_q)) begin
            key_d = cache_rk_q;
            rnd_d = 4'd10;
            st_d  = StInit;
          end else begin
            cache_key_d = key_in;
            cache_vld_d = 1'b0;
          end
`endif
        end
      end
      StKeyexp: begin
        key_d = key_fwd;
        if (rnd_q == 4'd10) begin
          st_d = StInit;
`ifdef AES_INV_KEY_CACHE_EN
          cache_rk_d  = key_fwd;
          cache_vld_d = 1'b1;
`endif
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      StInit: begin
        state_d = state_q ^ key_q;
        key_d   = key_inv;
        rnd_d   = rnd_q - 4'd1;
        st_d    = StRound;
      end
      StRound: begin
        state_d = inv_mix(sr_sb ^ key_q);
        key_d   = key_inv;
        rnd_d   = rnd_q - 4'd1;
        if (rnd_q == 4'd1) st_d = StFinal;
      end
      StFinal: begin
        pt_d    = sr_sb ^ key_q;
        valid_d = 1'b1;
        st_d    = StDone;
      end
      StDone: begin
        if (ready_out) begin
          valid_d = 1'b0;
          st_d    = StIdle;
          if (CLEAR_OUTPUT) pt_d = '0;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= StIdle;
      state_q <= '0;
      key_q   <= '0;
      rnd_q   <= '0;
      valid_q <= 1'b0;
      pt_q    <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
      valid_q <= valid_d;
      pt_q    <= pt_d;
    end
  end

`ifdef AES_INV_KEY_CACHE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_key_q <= '0;
      cache_rk_q  <= '0;
      cache_vld_q <= 1'b0;
    end else begin
      cache_key_q <= cache_key_d;
      cache_rk_q  <= cache_rk_d;
      cache_vld_q <= cache_vld_d;
    end
  end
`endif

  assign ready_in      = (st_q == StIdle);
  assign valid_out     = valid_q;
  assign plaintext_out = pt_q;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Bench for aes_inv_cipher: textbook FIPS-197 decrypt model with handshake/latency model,
// checked every cycle, plus directed known-answer vectors.
module tb_aes_inv_cipher;

  localparam bit ClearOut = 1'b1;
`ifdef AES_INV_KEY_CACHE_EN
  localparam bit CacheEn = 1'b1;
  localparam int HitLat  = 11;
`else
  localparam bit CacheEn = 1'b0;
  localparam int HitLat  = 21;
`endif

  localparam logic [127:0] C1K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V2K  = 128'hF0F34A2B53422D415F4BDC952E15EADA;
  localparam logic [127:0] V2CT = 128'ha4e1183ba88abbeff971415195c0b975;
  localparam logic [127:0] V2PT = 128'hD50F91ECB37BF79A804BB6BC3FBF8C63;
  localparam logic [127:0] V3K  = 128'h14367CFBF6A3F8DE3716ECAAB0D02FEF;
  localparam logic [127:0] V3CT = 128'h9793d5b514c8771736f6fbf7b6b0dc67;
  localparam logic [127:0] V3PT = 128'h23216D96FE77AC6771DAD1F66C5C595D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_in = 1'b0;
  logic         ready_out = 1'b0;
  logic [127:0] ciphertext_in = '0;
  logic [127:0] key_in = '0;
  logic         ready_in;
  logic         valid_out;
  logic [127:0] plaintext_out;

  int total = 0;
  int bad = 0;

  logic [7:0] sb[256];
  logic [7:0] isb[256];

  aes_inv_cipher #(.CLEAR_OUTPUT(ClearOut)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .ready_in     (ready_in),
    .ciphertext_in(ciphertext_in),
    .key_in       (key_in),
    .ready_out    (ready_out),
    .valid_out    (valid_out),
    .plaintext_out(plaintext_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box tables via the generator-3 walk: p runs over powers of 3, q over powers of 3^-1.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int i = 0; i < 255; i++) begin
      p = p ^ xt(p);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
      sb[p] = x;
    end
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
  endtask

  function automatic logic [127:0] m_decrypt(input logic [127:0] ct, input logic [127:0] k);
    logic [31:0] w[44];
    logic [7:0]  s[16];
    logic [7:0]  t[16];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [127:0] r;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = ct[127-8*b -: 8] ^ w[40 + b/4][31-8*(b%4) -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int b = 0; b < 16; b++) t[b] = isb[s[(b%4) + 4*(((b/4) - (b%4) + 4) % 4)]];
      for (int b = 0; b < 16; b++) s[b] = t[b] ^ w[4*rnd + b/4][31-8*(b%4) -: 8];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++) begin
          t[4*c]   = gm(s[4*c], 14) ^ gm(s[4*c+1], 11) ^ gm(s[4*c+2], 13) ^ gm(s[4*c+3], 9);
          t[4*c+1] = gm(s[4*c], 9) ^ gm(s[4*c+1], 14) ^ gm(s[4*c+2], 11) ^ gm(s[4*c+3], 13);
          t[4*c+2] = gm(s[4*c], 13) ^ gm(s[4*c+1], 9) ^ gm(s[4*c+2], 14) ^ gm(s[4*c+3], 11);
          t[4*c+3] = gm(s[4*c], 11) ^ gm(s[4*c+1], 13) ^ gm(s[4*c+2], 9) ^ gm(s[4*c+3], 14);
        end
        for (int b = 0; b < 16; b++) s[b] = t[b];
      end
    end
    for (int b = 0; b < 16; b++) r[127-8*b -: 8] = s[b];
    return r;
  endfunction

  // Transaction-level model: idle / busy for a fixed number of edges / holding a result.
  int           m_st = 0;
  int           m_k = 0;
  int           m_lat = 21;
  logic         m_rdy = 1'b1;
  logic         m_valid = 1'b0;
  logic [127:0] m_pt = '0;
  logic [127:0] m_exp = '0;
  logic         m_cvld = 1'b0;
  logic [127:0] m_ckey = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st    <= 0;
      m_rdy   <= 1'b1;
      m_valid <= 1'b0;
      m_pt    <= '0;
      m_cvld  <= 1'b0;
    end else begin
      case (m_st)
        0: if (valid_in) begin
          m_exp <= m_decrypt(ciphertext_in, key_in);
          m_k   <= 0;
          m_rdy <= 1'b0;
          m_st  <= 1;
          if (CacheEn && m_cvld && key_in == m_ckey) begin
            m_lat <= 11;
          end else begin
            m_lat  <= 21;
            m_ckey <= key_in;
            m_cvld <= 1'b0;
          end
        end
        1: begin
          m_k <= m_k + 1;
          if (m_lat == 21 && m_k + 1 == 10) m_cvld <= 1'b1;
          if (m_k + 1 == m_lat) begin
            m_valid <= 1'b1;
            m_pt    <= m_exp;
            m_st    <= 2;
          end
        end
        default: if (ready_out) begin
          m_valid <= 1'b0;
          m_rdy   <= 1'b1;
          if (ClearOut) m_pt <= '0;
          m_st    <= 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    check("cyc ready_in", 128'(ready_in), 128'(m_rdy));
    check("cyc valid_out", 128'(valid_out), 128'(m_valid));
    check("cyc plaintext_out", plaintext_out, m_pt);
  end

  task automatic wait_ready();
    int w;
    w = 0;
    while (ready_in !== 1'b1 && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("ready_in wait", 128'(ready_in), 128'(1));
  endtask

  task automatic wait_valid(input int start, output int n);
    n = start;
    while (valid_out !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // hold < 0: ready_out already high when the result appears.
  task automatic do_op(input logic [127:0] ct, input logic [127:0] k, input logic [127:0] exp,
                       input int exp_lat, input int hold, input string nm);
    int n;
    wait_ready();
    if (hold < 0) ready_out = 1'b1;
    ciphertext_in = ct;
    key_in        = k;
    valid_in      = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    wait_valid(0, n);
    check({nm, " latency"}, 128'(n), 128'(exp_lat));
    check({nm, " plaintext"}, plaintext_out, exp);
    if (hold < 0) begin
      @(posedge clk);
      #1;
      check({nm, " one-cycle valid"}, 128'(valid_out), 128'(0));
      ready_out = 1'b0;
    end else begin
      repeat (hold) begin
        @(posedge clk);
        #1;
      end
      check({nm, " held valid"}, 128'(valid_out), 128'(1));
      check({nm, " held plaintext"}, plaintext_out, exp);
      check({nm, " held ready_in"}, 128'(ready_in), 128'(0));
      ready_out = 1'b1;
      @(posedge clk);
      #1;
      ready_out = 1'b0;
      check({nm, " release valid"}, 128'(valid_out), 128'(0));
      check({nm, " release ready_in"}, 128'(ready_in), 128'(1));
      check({nm, " release plaintext"}, plaintext_out, ClearOut ? 128'h0 : exp);
    end
  endtask

  initial begin
    logic [127:0] ct, k;
    int n;
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset ready_in", 128'(ready_in), 128'(1));
    check("reset valid_out", 128'(valid_out), 128'(0));
    check("reset plaintext_out", plaintext_out, 128'h0);

    check("model sbox 00", 128'(sb[8'h00]), 128'h63);
    check("model sbox 53", 128'(sb[8'h53]), 128'hed);
    check("model isbox 63", 128'(isb[8'h63]), 128'h00);
    check("model gmul 57*83", 128'(gm(8'h57, 8'h83)), 128'hc1);
    check("model C.1", m_decrypt(C1CT, C1K), C1PT);
    check("model v2", m_decrypt(V2CT, V2K), V2PT);

    do_op(C1CT, C1K, C1PT, 21, 15, "c1 backpressure");
    do_op(V2CT, V2K, V2PT, 21, 0, "v2");
    do_op(V3CT, V3K, V3PT, 21, 3, "v3");
    ct = {$urandom, $urandom, $urandom, $urandom};
    k  = {$urandom, $urandom, $urandom, $urandom};
    do_op(ct, k, m_decrypt(ct, k), 21, -1, "pre-ready");

    // Inputs wiggle while busy; the accepted C.1 job must be unaffected.
    wait_ready();
    ciphertext_in = C1CT;
    key_in        = C1K;
    valid_in      = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      valid_in      = 1'($urandom_range(0, 1));
      ciphertext_in = {$urandom, $urandom, $urandom, $urandom};
      key_in        = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    wait_valid(8, n);
    check("busy latency", 128'(n), 128'(21));
    check("busy plaintext", plaintext_out, C1PT);
    ready_out = 1'b1;
    @(posedge clk);
    #1;
    ready_out = 1'b0;

    for (int i = 0; i < 3; i++) begin
      ct = {$urandom, $urandom, $urandom, $urandom};
      k  = {$urandom, $urandom, $urandom, $urandom};
      do_op(ct, k, m_decrypt(ct, k), 21, i + 1, "random");
    end

    // Abort mid-operation.
    wait_ready();
    ciphertext_in = C1CT;
    key_in        = C1K;
    valid_in      = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort ready_in", 128'(ready_in), 128'(1));
    check("abort valid_out", 128'(valid_out), 128'(0));
    check("abort plaintext_out", plaintext_out, 128'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    do_op(C1CT, C1K, C1PT, 21, 2, "c1 after reset");
    do_op(C1CT, C1K, C1PT, HitLat, 0, "c1 same key");
    do_op(V2CT, V2K, V2PT, 21, 0, "v2 new key");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
